// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and state encoding for the register-file write arbiter.
package rf_pkg;
    localparam int RF_AW    = 5;
    localparam int RF_DW    = 32;
    localparam int RF_NREGS = 32;

    // Requester slots on the arbiter's request vector
    localparam int REQ_WB  = 0;
    localparam int REQ_MC  = 1;
    localparam int REQ_DBG = 2;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;
endpackage

// File: rtl/rf_write_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or above ptr,
// wrapping modulo NREQ, wins. Produces a one-hot grant and the winner index.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            any
);
    int   cand;
    logic found;

    // Scan NREQ positions starting at ptr; latch onto the first valid one
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = PW'(cand);
            end
        end
        any = found;
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: round-robin grant among NREQ valid/ready
// requesters, registered rf_we/rf_waddr/rf_wdata output stage.
// Optional feature macro RF_CLEAR_EN: after reset, a sequencer writes zero to
// registers 1..31 (one per cycle) before arbitration starts; busy is high
// meanwhile. Without the macro the block starts arbitrating immediately.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_waddr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata,
    output logic [2:0]         grant_id,
    output logic               busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic            run;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
    logic [2:0]      grant_id_q, grant_id_d;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign win_addr = req_waddr[int'(pick_idx)*AW +: AW];
    assign win_data = req_wdata[int'(pick_idx)*DW +: DW];

`ifdef RF_CLEAR_EN
    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;

    // Clear-sequencer state and address counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_CLEAR;
            cnt_q   <= 5'd1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Step through 1..31, then hand the port over to arbitration
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_CLEAR) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(RF_NREGS - 1)) state_d = S_RUN;
        end
    end

    assign run  = (state_q == S_RUN);
    assign busy = ~run;
`else
    assign run  = 1'b1;
    assign busy = 1'b0;
`endif

    // Ready is purely combinational; nothing is granted while clearing
    assign req_ready = run ? pick_gnt : '0;

    // Next output-stage values: clear write, accepted request, or idle
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        if (!run) begin
`ifdef RF_CLEAR_EN
            rf_we_d    = 1'b1;
            rf_waddr_d = AW'(cnt_q);
            rf_wdata_d = '0;
`endif
        end else if (pick_any) begin
            // r0 is hardwired zero: accept the request but suppress the write
            rf_we_d    = |win_addr;
            rf_waddr_d = win_addr;
            rf_wdata_d = win_data;
            grant_id_d = 3'(pick_idx);
            ptr_d      = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    // Registered write port and round-robin pointer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign grant_id = grant_id_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed literal tests plus a
// randomized phase, all cross-checked each cycle against a behavioural model.
`timescale 1ns/1ps
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
`ifdef RF_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic               clk;
    logic               resetn;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_waddr;
    logic [NREQ*DW-1:0] req_wdata;
    logic               rf_we;
    logic [AW-1:0]      rf_waddr;
    logic [DW-1:0]      rf_wdata;
    logic [2:0]         grant_id;
    logic               busy;

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_waddr (req_waddr),
        .req_wdata (req_wdata),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int            m_ptr;
    bit            m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            m_gid;
    bit            m_clear;
    int            m_cnt;
    int            m_win;
    logic [NREQ-1:0] m_rdy;
    logic [DW-1:0] m_rf [32];
    logic [DW-1:0] d_rf [32];
    int            wt [NREQ];
    logic [NREQ-1:0] rdy_s;

    function automatic int pick(logic [NREQ-1:0] v, int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    always_comb begin
        m_win = pick(req_valid, m_ptr);
        m_rdy = '0;
        if (!m_clear && m_win >= 0) m_rdy[m_win] = 1'b1;
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_ptr <= 0; m_we <= 1'b0; m_waddr <= '0; m_wdata <= '0; m_gid <= 0;
            m_clear <= CLR; m_cnt <= 1;
        end else if (m_clear) begin
            m_we    <= 1'b1;
            m_waddr <= AW'(m_cnt);
            m_wdata <= '0;
            m_rf[m_cnt] <= '0;
            m_cnt   <= m_cnt + 1;
            if (m_cnt == 31) m_clear <= 1'b0;
        end else if (m_win >= 0) begin
            m_waddr <= req_waddr[m_win*AW +: AW];
            m_wdata <= req_wdata[m_win*DW +: DW];
            m_we    <= (req_waddr[m_win*AW +: AW] != 0);
            m_gid   <= m_win;
            m_ptr   <= (m_win + 1) % NREQ;
            if (req_waddr[m_win*AW +: AW] != 0)
                m_rf[req_waddr[m_win*AW +: AW]] <= req_wdata[m_win*DW +: DW];
        end else begin
            m_we <= 1'b0;
        end
    end

    // DUT-side register file, captured mid-cycle from the write port
    always @(negedge clk) begin
        rdy_s <= req_ready;
        if (resetn && rf_we) d_rf[rf_waddr] <= rf_wdata;
    end

    // Per-cycle comparison against the model, plus a wait-bound check
    always @(negedge clk) begin
        if (resetn) begin
            chk("ready", req_ready, m_rdy);
            chk("rf_we", rf_we, m_we);
            chk("rf_waddr", rf_waddr, m_waddr);
            chk("rf_wdata", rf_wdata, m_wdata);
            chk("grant_id", grant_id, m_gid);
            chk("busy", busy, m_clear);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!resetn || busy) wt[i] <= 0;
            else if (req_ready[i]) begin
                chk("fair_wait", (wt[i] <= NREQ - 1), 1);
                wt[i] <= 0;
            end else if (req_valid[i]) wt[i] <= wt[i] + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_req(int i, logic [AW-1:0] a, logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_waddr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_run();
        for (int k = 0; k < 40 && busy; k++) step();
        chk("clear_done", busy, 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0; req_valid = '0;
        step();
        resetn = 1'b1;
        wait_run();
    endtask

    initial begin
        logic [AW-1:0] ra;
        resetn = 1'b0; req_valid = '0; req_waddr = '0; req_wdata = '0;
        for (int i = 0; i < 32; i++) begin m_rf[i] = 'x; d_rf[i] = 'x; end
        for (int i = 0; i < NREQ; i++) wt[i] = 0;
        step(); step();

        // reset values while reset is held
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_busy", busy, CLR);

`ifdef RF_CLEAR_EN
        // clear sequence with all requesters valid
        req_valid = 3'b111;
        resetn = 1'b1;
        for (int k = 0; k < 31; k++) begin
            chk("clr_busy", busy, 1);
            chk("clr_ready", req_ready, 0);
            step();
            chk("clr_we", rf_we, 1);
            chk("clr_waddr", rf_waddr, k + 1);
            chk("clr_wdata", rf_wdata, 0);
        end
        chk("clr_end_busy", busy, 0);
        chk("clr_first_ready", req_ready, 3'b001);
`endif

        // single request from the multi-cycle unit
        do_reset();
        set_req(REQ_MC, 5'd9, 32'h5); #1;
        chk("single_ready", req_ready, 3'b010);
        step(); req_valid = '0;
        chk("single_we", rf_we, 1);
        chk("single_waddr", rf_waddr, 9);
        chk("single_wdata", rf_wdata, 32'h5);
        chk("single_gid", grant_id, 1);
        step();
        chk("single_idle_we", rf_we, 0);

        // all valid continuously: 0,1,2,0,1,2
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), DW'(i)); #1;
        chk("rr_first_ready", req_ready, 3'b001);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_gid", grant_id, k % 3);
            chk("rr_waddr", rf_waddr, (k % 3) + 1);
        end
        req_valid = '0;

        // write to r0: accepted, no write, pointer advances
        do_reset();
        set_req(0, 5'd0, 32'hFFFF); #1;
        chk("r0_ready", req_ready, 3'b001);
        step(); req_valid = '0;
        chk("r0_we", rf_we, 0);
        chk("r0_gid", grant_id, 0);
        for (int i = 0; i < NREQ; i++) set_req(i, 5'd2, 32'h1); #1;
        chk("r0_ptr_next", req_ready, 3'b010);
        step(); req_valid = '0;

        // same address from requesters 0 and 2
        do_reset();
        set_req(0, 5'd13, 32'h7);
        set_req(2, 5'd13, 32'h8); #1;
        chk("same_ready0", req_ready, 3'b001);
        step(); req_valid[0] = 1'b0;
        chk("same_wdata0", rf_wdata, 32'h7);
        chk("same_waddr0", rf_waddr, 13);
        #1;
        chk("same_ready2", req_ready, 3'b100);
        step(); req_valid = '0;
        chk("same_wdata2", rf_wdata, 32'h8);
        chk("same_gid2", grant_id, 2);
        @(negedge clk); #1;
        chk("same_r13_dut", d_rf[13], 32'h8);
        chk("same_r13_model", m_rf[13], 32'h8);

        // asynchronous reset while a write is on the port
        do_reset();
        set_req(1, 5'd20, 32'hABC); #1;
        step(); req_valid = '0;
        chk("arst_pre_we", rf_we, 1);
        #1 resetn = 1'b0;
        #1;
        chk("arst_we", rf_we, 0);
        chk("arst_waddr", rf_waddr, 0);
        chk("arst_gid", grant_id, 0);
        step(); resetn = 1'b1;
`ifdef RF_CLEAR_EN
        chk("arst_busy", busy, 1);
        step();
        chk("arst_clr_addr", rf_waddr, 1);
        wait_run();
`else
        set_req(2, 5'd3, 32'h3); #1;
        chk("arst_ready", req_ready, 3'b100);
        step(); req_valid = '0;
        chk("arst_gid2", grant_id, 2);
`endif

        // randomized traffic honouring the hold-until-ready protocol
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && rdy_s[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 3) != 0) begin
                    ra = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                    set_req(i, ra, $urandom);
                end
            end
        end
        step(); req_valid = '0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
